// File: rtl/router_pkg.sv
// Shared definitions for the router read-side synchronizer: default sizes
// and the per-channel packet framing state encoding.
package router_pkg;

   localparam int WIDTH_DEF   = 8;
   localparam int TIMEOUT_DEF = 30;

   typedef enum logic [1:0] {
      ST_HDR     = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_PARITY  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/router_rd_sync_if.sv
// Bundle of FIFO-side and consumer-side signals for the three router output
// channels. The master side is the FIFO/consumer environment; the slave is the synchronizer.
interface router_rd_sync_if
   import router_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
);
   logic             vld_out_0;
   logic             vld_out_1;
   logic             vld_out_2;
   logic             read_req_0;
   logic             read_req_1;
   logic             read_req_2;
   logic [WIDTH-1:0] data_out_0;
   logic [WIDTH-1:0] data_out_1;
   logic [WIDTH-1:0] data_out_2;
   logic [2:0]       read_enb;
   logic             soft_reset_0;
   logic             soft_reset_1;
   logic             soft_reset_2;
   logic [WIDTH-1:0] dout_0;
   logic [WIDTH-1:0] dout_1;
   logic [WIDTH-1:0] dout_2;
   logic             dout_vld_0;
   logic             dout_vld_1;
   logic             dout_vld_2;
   logic             pkt_done_0;
   logic             pkt_done_1;
   logic             pkt_done_2;
   logic             parity_err_0;
   logic             parity_err_1;
   logic             parity_err_2;

   modport master (
      output vld_out_0, vld_out_1, vld_out_2,
      output read_req_0, read_req_1, read_req_2,
      output data_out_0, data_out_1, data_out_2,
      input  read_enb,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  dout_0, dout_1, dout_2,
      input  dout_vld_0, dout_vld_1, dout_vld_2,
      input  pkt_done_0, pkt_done_1, pkt_done_2,
      input  parity_err_0, parity_err_1, parity_err_2
   );

   modport slave (
      input  vld_out_0, vld_out_1, vld_out_2,
      input  read_req_0, read_req_1, read_req_2,
      input  data_out_0, data_out_1, data_out_2,
      output read_enb,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output dout_0, dout_1, dout_2,
      output dout_vld_0, dout_vld_1, dout_vld_2,
      output pkt_done_0, pkt_done_1, pkt_done_2,
      output parity_err_0, parity_err_1, parity_err_2
   );

endinterface

// File: rtl/router_rd_chan.sv
// One read channel: FIFO read gating, output byte register, packet framing
// with parity check, and a stale-data watchdog that flushes the FIFO.
module router_rd_chan
   import router_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             vld_out,
   input  logic             read_req,
   input  logic [WIDTH-1:0] data_out,
   output logic             read_enb,
   output logic             soft_reset,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   output logic             pkt_done,
   output logic             parity_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   function automatic logic [WIDTH-1:0] parity_acc(input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] b);
      return acc ^ b;
   endfunction

   rd_state_t        state_r;
   rd_state_t        state_s;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] acc_s;
   logic [WIDTH-1:0] len_r;
   logic [WIDTH-1:0] len_s;
   logic             done_s;
   logic             err_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             wd_fire_s;
   logic             rd_q_r;
   logic             soft_reset_r;
   logic [WIDTH-1:0] dout_r;
   logic             dout_vld_r;
   logic             pkt_done_r;
   logic             parity_err_r;

   // Never strobe the FIFO while it is being flushed or while in reset.
   assign read_enb   = vld_out & read_req & ~soft_reset_r & reset;
   assign soft_reset = soft_reset_r;
   assign dout       = dout_r;
   assign dout_vld   = dout_vld_r;
   assign pkt_done   = pkt_done_r;
   assign parity_err = parity_err_r;

   // Watchdog: count stalled-valid cycles, fire once the limit is reached.
   always_comb begin
      cnt_s     = cnt_r;
      wd_fire_s = 1'b0;
      if (soft_reset_r) begin
         cnt_s = {CNT_W{1'b0}};
      end else if (vld_out && !read_enb) begin
         if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            wd_fire_s = 1'b1;
            cnt_s     = {CNT_W{1'b0}};
         end else begin
            cnt_s = cnt_r + CNT_W'(1);
         end
      end else begin
         cnt_s = {CNT_W{1'b0}};
      end
   end

   // Framing next-state: one step per consumed byte; a flush discards the byte in flight.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      len_s   = len_r;
      done_s  = 1'b0;
      err_s   = 1'b0;
      if (soft_reset_r) begin
         state_s = ST_HDR;
         acc_s   = {WIDTH{1'b0}};
         len_s   = {WIDTH{1'b0}};
      end else if (rd_q_r) begin
         case (state_r)
            ST_HDR: begin
               acc_s   = data_out;
               state_s = ST_LEN;
            end
            ST_LEN: begin
               len_s = data_out;
               acc_s = parity_acc(acc_r, data_out);
               if (data_out != {WIDTH{1'b0}}) begin
                  state_s = ST_PAYLOAD;
               end else begin
                  state_s = ST_PARITY;
               end
            end
            ST_PAYLOAD: begin
               acc_s = parity_acc(acc_r, data_out);
               len_s = len_r - WIDTH'(1);
               if (len_r == WIDTH'(1)) begin
                  state_s = ST_PARITY;
               end else begin
                  state_s = ST_PAYLOAD;
               end
            end
            ST_PARITY: begin
               done_s  = 1'b1;
               err_s   = (data_out != acc_r);
               acc_s   = {WIDTH{1'b0}};
               state_s = ST_HDR;
            end
            default: begin
               state_s = ST_HDR;
               acc_s   = {WIDTH{1'b0}};
               len_s   = {WIDTH{1'b0}};
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, watchdog and registered outputs.
   always_ff @(posedge clk1 or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_HDR;
         acc_r        <= {WIDTH{1'b0}};
         len_r        <= {WIDTH{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         rd_q_r       <= 1'b0;
         soft_reset_r <= 1'b0;
         dout_r       <= {WIDTH{1'b0}};
         dout_vld_r   <= 1'b0;
         pkt_done_r   <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         acc_r        <= acc_s;
         len_r        <= len_s;
         cnt_r        <= cnt_s;
         rd_q_r       <= read_enb;
         soft_reset_r <= wd_fire_s;
         dout_vld_r   <= rd_q_r;
         pkt_done_r   <= done_s;
         parity_err_r <= err_s;
         if (rd_q_r) begin
            dout_r <= data_out;
         end else begin
            dout_r <= dout_r;
         end
      end
   end

endmodule

// File: rtl/router_rd_sync.sv
// Read-side synchronizer for the 1x3 router: three independent read channels
// between the router FIFOs and the output ports.
module router_rd_sync
   import router_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic           clk1,
   input  logic           reset,
   router_rd_sync_if.slave bus
);

   logic [2:0] read_enb_s;

   assign bus.read_enb = read_enb_s;

   router_rd_chan #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_chan_0 (
      .clk1       (clk1),
      .reset      (reset),
      .vld_out    (bus.vld_out_0),
      .read_req   (bus.read_req_0),
      .data_out   (bus.data_out_0),
      .read_enb   (read_enb_s[0]),
      .soft_reset (bus.soft_reset_0),
      .dout       (bus.dout_0),
      .dout_vld   (bus.dout_vld_0),
      .pkt_done   (bus.pkt_done_0),
      .parity_err (bus.parity_err_0)
   );

   router_rd_chan #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_chan_1 (
      .clk1       (clk1),
      .reset      (reset),
      .vld_out    (bus.vld_out_1),
      .read_req   (bus.read_req_1),
      .data_out   (bus.data_out_1),
      .read_enb   (read_enb_s[1]),
      .soft_reset (bus.soft_reset_1),
      .dout       (bus.dout_1),
      .dout_vld   (bus.dout_vld_1),
      .pkt_done   (bus.pkt_done_1),
      .parity_err (bus.parity_err_1)
   );

   router_rd_chan #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) u_chan_2 (
      .clk1       (clk1),
      .reset      (reset),
      .vld_out    (bus.vld_out_2),
      .read_req   (bus.read_req_2),
      .data_out   (bus.data_out_2),
      .read_enb   (read_enb_s[2]),
      .soft_reset (bus.soft_reset_2),
      .dout       (bus.dout_2),
      .dout_vld   (bus.dout_vld_2),
      .pkt_done   (bus.pkt_done_2),
      .parity_err (bus.parity_err_2)
   );

endmodule

// File: tb/tb_router_rd_sync.sv
// Bench for router_rd_sync: FIFO models feed the channels, expected bytes and
// flags are queued per channel when a packet is loaded and checked on output.
module tb_router_rd_sync;
   import router_pkg::*;

   typedef struct {
      int         ch;
      int         n;
      logic [7:0] b [8];
      logic       err;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic       done;
      logic       err;
   } exp_t;

   logic clk1 = 1'b0;
   logic reset;
   always #5 clk1 = ~clk1;

   router_rd_sync_if #(.WIDTH(8)) bus ();

   router_rd_sync #(.WIDTH(8), .TIMEOUT(30)) dut (
      .clk1  (clk1),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] fq [3][$];
   exp_t       eq [3][$];
   bit         chk_en [3];
   int         n_tests = 0;
   int         n_fail  = 0;
   vec_t       vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input int ch, input int n, input logic err, input logic [63:0] bytes);
      vec_t v;
      v.ch  = ch;
      v.n   = n;
      v.err = err;
      for (int k = 0; k < 8; k++) v.b[k] = bytes[63-8*k -: 8];
      return v;
   endfunction

   function automatic logic [63:0] all_outs();
      return {25'd0, bus.read_enb, bus.soft_reset_0, bus.soft_reset_1, bus.soft_reset_2,
              bus.dout_0, bus.dout_1, bus.dout_2,
              bus.dout_vld_0, bus.dout_vld_1, bus.dout_vld_2,
              bus.pkt_done_0, bus.pkt_done_1, bus.pkt_done_2,
              bus.parity_err_0, bus.parity_err_1, bus.parity_err_2};
   endfunction

   function automatic logic [10:0] obs(input int ch);
      case (ch)
         0:       return {bus.dout_vld_0, bus.pkt_done_0, bus.parity_err_0, bus.dout_0};
         1:       return {bus.dout_vld_1, bus.pkt_done_1, bus.parity_err_1, bus.dout_1};
         default: return {bus.dout_vld_2, bus.pkt_done_2, bus.parity_err_2, bus.dout_2};
      endcase
   endfunction

   task automatic load(input vec_t v, input bit expect_out);
      for (int k = 0; k < v.n; k++) begin
         if (expect_out)
            eq[v.ch].push_back('{d: v.b[k], done: (k == v.n - 1), err: ((k == v.n - 1) && v.err)});
         fq[v.ch].push_back(v.b[k]);
      end
   endtask

   task automatic wait_drain(input string name);
      bit empty;
      empty = 1'b0;
      for (int k = 0; k < 400 && !empty; k++) begin
         @(negedge clk1);
         empty = 1'b1;
         for (int c = 0; c < 3; c++)
            if (fq[c].size() != 0 || (chk_en[c] && eq[c].size() != 0)) empty = 1'b0;
      end
      check({name, " drained"}, 64'(empty), 64'd1);
   endtask

   // FIFO models: data valid one cycle after read_enb, flushed by soft_reset or reset.
   initial begin : fifo_model
      logic [2:0] re;
      logic [2:0] sr;
      logic [7:0] dq [3];
      for (int c = 0; c < 3; c++) dq[c] = 8'h00;
      forever begin
         @(posedge clk1);
         re = bus.read_enb;
         sr = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
         #1;
         for (int c = 0; c < 3; c++) begin
            if (!reset || sr[c]) fq[c].delete();
            else if (re[c] && fq[c].size() != 0) dq[c] = fq[c].pop_front();
         end
         bus.vld_out_0  = (fq[0].size() != 0);
         bus.vld_out_1  = (fq[1].size() != 0);
         bus.vld_out_2  = (fq[2].size() != 0);
         bus.data_out_0 = dq[0];
         bus.data_out_1 = dq[1];
         bus.data_out_2 = dq[2];
      end
   end

   // Scoreboard: every output byte must match the next expected record.
   initial begin : monitor
      logic [10:0] o;
      exp_t        e;
      forever begin
         @(negedge clk1);
         for (int c = 0; c < 3; c++) begin
            o = obs(c);
            if (chk_en[c]) begin
               if (o[10]) begin
                  if (eq[c].size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL ch%0d unexpected byte: got %0h, required none", c, o[7:0]);
                  end else begin
                     e = eq[c].pop_front();
                     check($sformatf("ch%0d byte", c), {53'd0, o[7:0], o[9], o[8]},
                           {53'd0, e.d, e.done, e.err});
                  end
               end else if (o[9] || o[8]) begin
                  check($sformatf("ch%0d stray flag", c), {62'd0, o[9], o[8]}, 64'd0);
               end
            end
         end
      end
   end

   task automatic wd_run(input bit raise);
      bit found;
      bus.read_req_2 = 1'b0;
      load(vecs[3], raise);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk1);
         found = bus.vld_out_2;
      end
      check("wd vld_out_2 seen", 64'(found), 64'd1);
      for (int c = 1; c <= 36; c++) begin
         check($sformatf("wd%0d soft_reset_2 c%0d", raise, c), 64'(bus.soft_reset_2),
               64'(!raise && c == 31));
         if (!raise) check($sformatf("wd read_enb2 c%0d", c), 64'(bus.read_enb[2]), 64'd0);
         if (raise && c == 29) bus.read_req_2 = 1'b1;
         @(negedge clk1);
      end
      bus.read_req_2 = 1'b1;
      wait_drain($sformatf("wd%0d", raise));
   endtask

   initial begin : main
      bit found;
      int seen;
      vec_t v;
      vecs[0] = mk(0, 5, 1'b0, 64'h05_02_A1_3C_9A_00_00_00);
      vecs[1] = mk(0, 5, 1'b1, 64'h05_02_A1_3C_00_00_00_00);
      vecs[2] = mk(1, 3, 1'b0, 64'h90_00_90_00_00_00_00_00);
      vecs[3] = mk(2, 6, 1'b0, 64'h12_03_01_02_04_16_00_00);
      vecs[4] = mk(1, 4, 1'b1, 64'hAA_01_FF_55_00_00_00_00);
      for (int c = 0; c < 3; c++) chk_en[c] = 1'b1;

      reset = 1'b0;
      bus.read_req_0 = 1'b0; bus.read_req_1 = 1'b0; bus.read_req_2 = 1'b0;
      bus.vld_out_0  = 1'b0; bus.vld_out_1  = 1'b0; bus.vld_out_2  = 1'b0;
      bus.data_out_0 = 8'h00; bus.data_out_1 = 8'h00; bus.data_out_2 = 8'h00;
      repeat (2) @(negedge clk1);
      check("reset outputs", all_outs(), 64'd0);
      reset = 1'b1;
      bus.read_req_0 = 1'b1; bus.read_req_1 = 1'b1; bus.read_req_2 = 1'b1;

      // Latency and back-to-back throughput on channel 0.
      load(vecs[0], 1'b1);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk1);
         found = bus.read_enb[0];
      end
      check("lat read_enb0 seen", 64'(found), 64'd1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk1);
         check($sformatf("lat dout_vld_0 +%0d", k), 64'(bus.dout_vld_0), 64'(k >= 2 && k <= 6));
      end
      wait_drain("lat");

      for (int i = 0; i < 5; i++) begin
         load(vecs[i], 1'b1);
         wait_drain($sformatf("vec%0d", i));
      end

      wd_run(1'b0);
      wd_run(1'b1);

      // All channels at once, with read_req_1 toggling.
      load(vecs[0], 1'b1);
      load(vecs[4], 1'b1);
      load(vecs[3], 1'b1);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk1);
         bus.read_req_1 = ~bus.read_req_1;
      end
      bus.read_req_1 = 1'b1;
      wait_drain("interleave");

      // Reset in PAYLOAD on channel 0, then a clean packet.
      chk_en[0] = 1'b0;
      load(vecs[0], 1'b0);
      seen = 0;
      for (int k = 0; k < 40 && seen < 3; k++) begin
         @(negedge clk1);
         if (bus.dout_vld_0) seen++;
      end
      check("rst reached payload", 64'(seen), 64'd3);
      reset = 1'b0;
      #1;
      check("rst outputs immediate", all_outs(), 64'd0);
      repeat (2) @(negedge clk1);
      check("rst outputs held", all_outs(), 64'd0);
      reset = 1'b1;
      chk_en[0] = 1'b1;
      v = vecs[1];
      load(v, 1'b1);
      wait_drain("post-reset");
      repeat (3) @(negedge clk1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
